// File: rtl/mbox_pkg.sv
// Shared definitions for the AXI-lite mailbox: register map, response codes
// and the state encodings of the write and read channel FSMs.
package mbox_pkg;

    localparam logic [4:0] OFF_DATA   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam logic [4:0] OFF_RSVD   = 5'h18;

    // Registers are 8 bytes apart, so addr[4:3] alone selects one of four.
    localparam logic [1:0] SEL_DATA   = OFF_DATA[4:3];
    localparam logic [1:0] SEL_STATUS = OFF_STATUS[4:3];
    localparam logic [1:0] SEL_CTRL   = OFF_CTRL[4:3];
    localparam logic [1:0] SEL_RSVD   = OFF_RSVD[4:3];

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

endpackage

// File: rtl/mbox_fifo.sv
// Mailbox storage: circular buffer with synchronous write, combinational head
// read, and a flush that clears count and pointers ahead of push or pop.
module mbox_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Full/empty come from the count at the start of the cycle, so a push to a
    // full FIFO is refused even when a pop drains an entry in the same cycle.
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/axi_lite_mailbox.sv
// AXI-lite slave exposing a word FIFO: DATA pushes/pops, STATUS, CTRL (irq
// enable, flush). Independent write and read FSMs, one beat per transaction.
module axi_lite_mailbox
    import mbox_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int DEPTH              = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr,
    input  logic                            awvalid,
    output logic                            awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb,
    input  logic                            wvalid,
    output logic                            wready,
    output logic [1:0]                      bresp,
    output logic                            bvalid,
    input  logic                            bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr,
    input  logic                            arvalid,
    output logic                            arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                      rresp,
    output logic                            rvalid,
    input  logic                            rready,
    output logic                            irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int CW = $clog2(DEPTH) + 1;

    w_state_e      w_state_q, w_state_d;
    r_state_e      r_state_q, r_state_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [DW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] status_word;

    logic          unused_bits;
    assign unused_bits = ^{awaddr[C_S_AXI_ADDR_WIDTH-1:5], awaddr[2:0],
                           araddr[C_S_AXI_ADDR_WIDTH-1:5], araddr[2:0],
                           wstrb[SW-1:1]};

    assign status_word = DW'({fifo_count, 6'b0, fifo_full, fifo_empty});

    mbox_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .din_i   (wdata),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Write channel: address and data are taken together; the register effect
    // lands at the end of W_ACK while awready/wready are high.
    always_comb begin
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        irq_en_d   = irq_en_q;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && wvalid) begin
                    w_state_d = W_ACK;
                end
            end
            W_ACK: begin
                awready   = 1'b1;
                wready    = 1'b1;
                bresp_d   = RESP_OKAY;
                w_state_d = W_RESP;
                case (awaddr[4:3])
                    SEL_DATA: begin
                        fifo_push = 1'b1;
                        if (fifo_full) begin
                            bresp_d = RESP_SLVERR;
                        end
                    end
                    SEL_CTRL: begin
                        if (wstrb[0]) begin
                            irq_en_d   = wdata[0];
                            fifo_flush = wdata[1];
                        end
                    end
                    SEL_STATUS: ;
                    SEL_RSVD:   ;
                    default:    ;
                endcase
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: data is captured in R_ACK and held through R_DATA. A pop
    // coinciding with a flush sees an empty FIFO.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        fifo_pop  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_state_d = R_ACK;
                end
            end
            R_ACK: begin
                arready   = 1'b1;
                rdata_d   = '0;
                rresp_d   = RESP_OKAY;
                r_state_d = R_DATA;
                case (araddr[4:3])
                    SEL_DATA: begin
                        fifo_pop = 1'b1;
                        if (fifo_empty || fifo_flush) begin
                            rresp_d = RESP_SLVERR;
                        end else begin
                            rdata_d = fifo_dout;
                        end
                    end
                    SEL_STATUS: rdata_d = status_word;
                    SEL_CTRL:   rdata_d = DW'(irq_en_q);
                    SEL_RSVD:   ;
                    default:    ;
                endcase
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_en_q & ~fifo_empty;
        end
    end

    assign bresp = bresp_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_axi_lite_mailbox.sv
// Directed bench for the AXI-lite mailbox: a table of single transactions
// followed by hand-written sequences for fill, irq, concurrency and reset.
module tb_axi_lite_mailbox;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    localparam logic [63:0] A_DATA   = 64'h00;
    localparam logic [63:0] A_STATUS = 64'h08;
    localparam logic [63:0] A_CTRL   = 64'h10;
    localparam logic [63:0] A_RSVD   = 64'h18;
    localparam logic [1:0]  OK       = 2'b00;
    localparam logic [1:0]  ERR      = 2'b10;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          irq;

    always #5 clk = ~clk;

    axi_lite_mailbox #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .DEPTH              (8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .irq     (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake", name);
    endtask

    // Called at a negedge; returns at the negedge after the B handshake, or
    // at the first negedge showing bvalid when bready is low.
    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, output logic [1:0] resp,
                             output logic irq_at_b);
        int n;
        resp     = 2'bxx;
        irq_at_b = 1'bx;
        awaddr   = addr;
        wdata    = data;
        wstrb    = strb;
        awvalid  = 1'b1;
        wvalid   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 50);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!awready) begin
            timeout_fail("aw_handshake");
            return;
        end
        chk("aw_latency", 64'(n), 64'd1);
        chk("wready_with_awready", {63'b0, wready}, 64'd1);
        @(negedge clk);
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            timeout_fail("b_handshake");
            return;
        end
        chk("b_latency", 64'(n), 64'd0);
        resp     = bresp;
        irq_at_b = irq;
        if (bready) @(negedge clk);
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [63:0] data,
                            output logic [1:0] resp);
        int n;
        data    = 64'hx;
        resp    = 2'bxx;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        arvalid = 1'b0;
        if (!arready) begin
            timeout_fail("ar_handshake");
            return;
        end
        chk("ar_latency", 64'(n), 64'd1);
        @(negedge clk);
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            timeout_fail("r_handshake");
            return;
        end
        chk("r_latency", 64'(n), 64'd0);
        data = rdata;
        resp = rresp;
        if (rready) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_awready"}, {63'b0, awready}, 64'd0);
        chk({tag, "_wready"},  {63'b0, wready},  64'd0);
        chk({tag, "_bvalid"},  {63'b0, bvalid},  64'd0);
        chk({tag, "_bresp"},   {62'b0, bresp},   64'd0);
        chk({tag, "_arready"}, {63'b0, arready}, 64'd0);
        chk({tag, "_rvalid"},  {63'b0, rvalid},  64'd0);
        chk({tag, "_rresp"},   {62'b0, rresp},   64'd0);
        chk({tag, "_rdata"},   rdata,            64'd0);
        chk({tag, "_irq"},     {63'b0, irq},     64'd0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input bit is_wr, input logic [63:0] addr, input logic [63:0] data,
                                input logic [7:0] strb, input logic [1:0] exp_resp,
                                input logic [63:0] exp_rdata);
        vec_t v;
        v.is_wr     = is_wr;
        v.addr      = addr;
        v.data      = data;
        v.strb      = strb;
        v.exp_resp  = exp_resp;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [1:0]  resp, resp2;
        logic [63:0] d;
        logic        irq_b;

        vecs.push_back(mk(0, A_STATUS, 0,        8'h00, OK,  64'h0001));
        vecs.push_back(mk(1, A_DATA,   64'hA5,   8'hFF, OK,  0));
        vecs.push_back(mk(1, A_DATA,   64'h5A,   8'hFF, OK,  0));
        vecs.push_back(mk(0, A_STATUS, 0,        8'h00, OK,  64'h0200));
        vecs.push_back(mk(0, A_DATA,   0,        8'h00, OK,  64'hA5));
        vecs.push_back(mk(0, A_DATA,   0,        8'h00, OK,  64'h5A));
        vecs.push_back(mk(0, A_STATUS, 0,        8'h00, OK,  64'h0001));
        vecs.push_back(mk(0, A_DATA,   0,        8'h00, ERR, 64'h0));
        vecs.push_back(mk(0, A_STATUS, 0,        8'h00, OK,  64'h0001));
        vecs.push_back(mk(1, A_RSVD,   64'hDEAD, 8'hFF, OK,  0));
        vecs.push_back(mk(0, A_RSVD,   0,        8'h00, OK,  64'h0));
        vecs.push_back(mk(1, A_CTRL,   64'h1,    8'hFE, OK,  0));
        vecs.push_back(mk(0, A_CTRL,   0,        8'h00, OK,  64'h0));
        vecs.push_back(mk(1, A_CTRL,   64'h1,    8'h01, OK,  0));
        vecs.push_back(mk(0, A_CTRL,   0,        8'h00, OK,  64'h1));
        vecs.push_back(mk(1, A_CTRL,   64'h0,    8'h01, OK,  0));
        vecs.push_back(mk(0, A_CTRL,   0,        8'h00, OK,  64'h0));
        vecs.push_back(mk(1, A_DATA,   64'h1234, 8'h00, OK,  0));
        vecs.push_back(mk(0, A_STATUS, 0,        8'h00, OK,  64'h0100));
        vecs.push_back(mk(0, A_DATA,   0,        8'h00, OK,  64'h1234));

        // Clock/reset
        rstn    = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven single transactions
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, irq_b);
                chk($sformatf("vec%0d_bresp", i), {62'b0, resp}, {62'b0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, d, resp);
                chk($sformatf("vec%0d_rresp", i), {62'b0, resp}, {62'b0, vecs[i].exp_resp});
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            end
        end

        // Overfill: 8 accepted, 9th refused; drain in order across pointer wrap
        for (int i = 0; i < 9; i++) begin
            axi_write(A_DATA, 64'h100 + 64'(i), 8'hFF, resp, irq_b);
            chk($sformatf("fill%0d_bresp", i), {62'b0, resp}, (i == 8) ? 64'(ERR) : 64'(OK));
        end
        axi_read(A_STATUS, d, resp);
        chk("full_status", d, 64'h0802);
        for (int i = 0; i < 8; i++) begin
            axi_read(A_DATA, d, resp);
            chk($sformatf("drain%0d_rdata", i), d, 64'h100 + 64'(i));
            chk($sformatf("drain%0d_rresp", i), {62'b0, resp}, 64'(OK));
        end
        axi_read(A_STATUS, d, resp);
        chk("drained_status", d, 64'h0001);

        // Interrupt: registered one cycle behind the FIFO state
        axi_write(A_CTRL, 64'h1, 8'h01, resp, irq_b);
        chk("irq_en_empty", {63'b0, irq}, 64'd0);
        axi_write(A_DATA, 64'h77, 8'hFF, resp, irq_b);
        chk("irq_at_bvalid", {63'b0, irq_b}, 64'd0);
        chk("irq_after_push", {63'b0, irq}, 64'd1);
        axi_read(A_DATA, d, resp);
        chk("irq_pop_rdata", d, 64'h77);
        chk("irq_after_pop", {63'b0, irq}, 64'd0);
        axi_write(A_DATA, 64'h88, 8'hFF, resp, irq_b);
        chk("irq_after_push2", {63'b0, irq}, 64'd1);
        axi_write(A_CTRL, 64'h3, 8'h01, resp, irq_b);
        chk("flush_bresp", {62'b0, resp}, 64'(OK));
        chk("irq_at_flush_bvalid", {63'b0, irq_b}, 64'd1);
        chk("irq_after_flush", {63'b0, irq}, 64'd0);
        axi_read(A_STATUS, d, resp);
        chk("flush_status", d, 64'h0001);
        axi_read(A_CTRL, d, resp);
        chk("ctrl_after_flush", d, 64'h1);
        axi_write(A_CTRL, 64'h0, 8'h01, resp, irq_b);

        // Flush and pop in the same cycle: pop sees empty
        axi_write(A_DATA, 64'h99, 8'hFF, resp, irq_b);
        fork
            axi_write(A_CTRL, 64'h2, 8'h01, resp, irq_b);
            axi_read(A_DATA, d, resp2);
        join
        chk("flushpop_rdata", d, 64'h0);
        chk("flushpop_rresp", {62'b0, resp2}, 64'(ERR));
        axi_read(A_STATUS, d, resp);
        chk("flushpop_status", d, 64'h0001);

        // Concurrent push/pop at full, then B held off by bready=0
        for (int i = 0; i < 8; i++) begin
            axi_write(A_DATA, 64'h200 + 64'(i), 8'hFF, resp, irq_b);
        end
        bready = 1'b0;
        fork
            axi_write(A_DATA, 64'h999, 8'hFF, resp, irq_b);
            axi_read(A_DATA, d, resp2);
        join
        chk("conc_bresp", {62'b0, resp}, 64'(ERR));
        chk("conc_rdata", d, 64'h200);
        chk("conc_rresp", {62'b0, resp2}, 64'(OK));
        awaddr  = A_RSVD;
        wdata   = 64'h0;
        wstrb   = 8'hFF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_bvalid", i), {63'b0, bvalid}, 64'd1);
            chk($sformatf("hold%0d_bresp", i), {62'b0, bresp}, 64'(ERR));
            chk($sformatf("hold%0d_awready", i), {63'b0, awready}, 64'd0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        @(negedge clk);
        chk("hold_release_bvalid", {63'b0, bvalid}, 64'd0);
        axi_read(A_STATUS, d, resp);
        chk("conc_status", d, 64'h0700);
        axi_read(A_DATA, d, resp);
        chk("conc_next_rdata", d, 64'h201);
        axi_write(A_CTRL, 64'h2, 8'h01, resp, irq_b);

        // Reset during R_DATA aborts the read and empties the FIFO
        axi_write(A_CTRL, 64'h1, 8'h01, resp, irq_b);
        axi_write(A_DATA, 64'h55, 8'hFF, resp, irq_b);
        rready = 1'b0;
        axi_read(A_STATUS, d, resp);
        chk("pre_reset_rdata", d, 64'h0100);
        chk("pre_reset_rvalid", {63'b0, rvalid}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rstn   = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        axi_read(A_STATUS, d, resp);
        chk("post_reset_status", d, 64'h0001);
        axi_read(A_CTRL, d, resp);
        chk("post_reset_ctrl", d, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
